// File: rtl/ofm_wb_pkg.sv
// Shared widths, payload types and FSM encoding for the OFM writeback packer.
package ofm_wb_pkg;

  localparam int unsigned LANES          = 16;
  localparam int unsigned LANE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_VEC  = 4;
  localparam int unsigned VEC_W          = LANES * LANE_W;
  localparam int unsigned LANES_PER_WORD = WORD_W / LANE_W;
  localparam int unsigned WIDX_W         = $clog2(WORDS_PER_VEC);

  typedef logic [VEC_W-1:0]  vec_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [WIDX_W-1:0] widx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Word w of a vector holds lanes 4w..4w+3, lowest lane in the low byte.
  function automatic word_t vec_word(input vec_t v, input widx_t w);
    return v[WORD_W*int'(w) +: WORD_W];
  endfunction

endpackage

// File: rtl/ofm_vec_fifo.sv
// Synchronous vector FIFO; push is accepted while full if a pop happens in the same cycle.
module ofm_vec_fifo
  import ofm_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  vec_t din,
  input  logic pop,
  output vec_t dout,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  vec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // A flush empties the queue; a push in the flush cycle becomes the new head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PTR_W'(1) : '0;
      count  <= push ? CNT_W'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (flush && push)  mem[0]      <= din;
    else if (do_push)   mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ofm_writeback_packer.sv
// Buffers activated PE vectors and writes them as 32-bit words into the OFM BRAM in HWC order.
module ofm_writeback_packer
  import ofm_wb_pkg::*;
#(
  parameter int unsigned OFM_W      = 54,
  parameter int unsigned OFM_H      = 54,
  parameter int unsigned OFM_C      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LANES-1:0]  in_valid,
  input  logic [VEC_W-1:0]  in_data,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              err_partial
);

  localparam int unsigned NUM_PIX       = OFM_W * OFM_H;
  localparam int unsigned NUM_GRP       = OFM_C / LANES;
  localparam int unsigned WORDS_PER_PIX = OFM_C / LANES_PER_WORD;
  localparam widx_t       LAST_W        = WIDX_W'(WORDS_PER_VEC - 1);

  state_t       state_q, state_d;
  widx_t        w_q;
  logic [31:0]  p_q, g_q;
  logic         overflow_q, err_q;
  vec_t         head;
  logic         fifo_full, fifo_empty;
  logic         full_vec, partial, capture_en;
  logic         adv_c, pop_c, last_c, push_c, flush_c, ovf_set;
  logic [31:0]  addr_c;

  assign full_vec   = (in_valid == '1);
  assign partial    = (in_valid != '0) && !full_vec;
  assign capture_en = start || (state_q == ACTIVE);
  assign adv_c      = (state_q == ACTIVE) && !fifo_empty;
  assign pop_c      = adv_c && (w_q == LAST_W);
  assign last_c     = pop_c && (g_q == NUM_GRP - 1) && (p_q == NUM_PIX - 1);
  // Anything arriving alongside the frame's final pop is beyond the frame count.
  assign push_c     = full_vec && (start || ((state_q == ACTIVE) && !last_c));
  assign flush_c    = start || last_c;
  assign ovf_set    = !start && (state_q == ACTIVE) && full_vec && fifo_full && !pop_c;
  assign addr_c     = BASE_ADDR + p_q * WORDS_PER_PIX + g_q * WORDS_PER_VEC + 32'(w_q);

  ofm_vec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (flush_c),
    .push  (push_c),
    .din   (vec_t'(in_data)),
    .pop   (pop_c),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE:  if (last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (start) state_d = ACTIVE;
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      ACTIVE: begin
        busy = 1'b1;
        if (!fifo_empty) begin
          wr_en   = 1'b1;
          wr_addr = addr_c;
          wr_data = vec_word(head, w_q);
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Word / pixel / channel-group counters; pixel is inner, group outer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q <= '0;
      p_q <= '0;
      g_q <= '0;
    end else if (start) begin
      w_q <= '0;
      p_q <= '0;
      g_q <= '0;
    end else if (adv_c) begin
      w_q <= w_q + WIDX_W'(1);
      if (pop_c) begin
        if (p_q == NUM_PIX - 1) begin
          p_q <= '0;
          g_q <= g_q + 32'd1;
        end else begin
          p_q <= p_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (start) begin
      overflow_q <= 1'b0;
      err_q      <= partial;
    end else begin
      if (ovf_set)                overflow_q <= 1'b1;
      if (capture_en && partial)  err_q      <= 1'b1;
    end
  end

  assign overflow    = overflow_q;
  assign err_partial = err_q;

endmodule
